// File: rtl/i2s_frame_receiver_pkg.sv
// Shared definitions for the I2S frame receiver: FSM state encoding and the
// default sample/count widths used by the receiver and its testbench.
package i2s_frame_receiver_pkg;

  localparam int WORD_BITS_DEF = 24;
  localparam int CNT_BITS_DEF  = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_ALIGN = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

endpackage

// File: rtl/i2s_input_sync.sv
// Brings the asynchronous I2S lines into the clk domain with equal-depth
// synchronizers and emits a one-clk bit strobe per bclk rise with aligned lrclk/d.
module i2s_input_sync
  import i2s_frame_receiver_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i2s_bclk,
  input  logic i2s_lrclk,
  input  logic i2s_d,
  output logic bit_vld,
  output logic bit_lrclk,
  output logic bit_d
);

  // Bit order in the synchronizer vectors: {bclk, lrclk, d}
  logic [2:0] in_p0_q, in_p0_d;
  logic [2:0] in_p1_q, in_p1_d;
  logic       bclk_p2_q, bclk_p2_d;
  logic       vld_p2_q, vld_p2_d;
  logic       lrclk_p2_q, lrclk_p2_d;
  logic       d_p2_q, d_p2_d;

  always_comb begin
    in_p0_d    = {i2s_bclk, i2s_lrclk, i2s_d};
    in_p1_d    = in_p0_q;
    // p2: previous synchronized bclk for rise detect; lrclk/d delayed alongside
    bclk_p2_d  = in_p1_q[2];
    vld_p2_d   = in_p1_q[2] & ~bclk_p2_q;
    lrclk_p2_d = in_p1_q[1];
    d_p2_d     = in_p1_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_p0_q    <= '0;
      in_p1_q    <= '0;
      bclk_p2_q  <= 1'b0;
      vld_p2_q   <= 1'b0;
      lrclk_p2_q <= 1'b0;
      d_p2_q     <= 1'b0;
    end else begin
      in_p0_q    <= in_p0_d;
      in_p1_q    <= in_p1_d;
      bclk_p2_q  <= bclk_p2_d;
      vld_p2_q   <= vld_p2_d;
      lrclk_p2_q <= lrclk_p2_d;
      d_p2_q     <= d_p2_d;
    end
  end

  assign bit_vld   = vld_p2_q;
  assign bit_lrclk = lrclk_p2_q;
  assign bit_d     = d_p2_q;

endmodule

// File: rtl/i2s_frame_receiver.sv
// I2S stereo frame receiver: aligns on the lrclk 1->0 edge, captures MSB-first
// words, publishes complete left/right pairs and flags short words.
module i2s_frame_receiver
  import i2s_frame_receiver_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int CNT_BITS  = CNT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 i2s_bclk,
  input  logic                 i2s_lrclk,
  input  logic                 i2s_d,
  output logic [WORD_BITS-1:0] pcm_left,
  output logic [WORD_BITS-1:0] pcm_right,
  output logic                 pcm_valid,
  output logic [CNT_BITS-1:0]  bit_cnt,
  output logic                 frame_err,
  input  logic                 err_clr
);

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  function automatic logic word_open(input logic [CNT_BITS-1:0] v);
    return int'(v) < WORD_BITS;
  endfunction

  logic bit_vld, bit_lrclk, bit_d;

  i2s_input_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_d     (i2s_d),
    .bit_vld   (bit_vld),
    .bit_lrclk (bit_lrclk),
    .bit_d     (bit_d)
  );

  state_t               state_q, state_d;
  logic                 lr_prev_q, lr_prev_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [WORD_BITS-1:0] left_hold_q, left_hold_d;
  logic                 left_ok_q, left_ok_d;
  logic [WORD_BITS-1:0] pcm_left_q, pcm_left_d;
  logic [WORD_BITS-1:0] pcm_right_q, pcm_right_d;
  logic                 pcm_valid_q, pcm_valid_d;
  logic [CNT_BITS-1:0]  bit_cnt_q, bit_cnt_d;
  logic                 frame_err_q, frame_err_d;

  logic                 trans_c, full_c, err_set_c;
  logic [CNT_BITS-1:0]  cnt_inc_c;
  logic [WORD_BITS-1:0] word_sh_c;

  always_comb begin
    trans_c     = bit_lrclk != lr_prev_q;
    cnt_inc_c   = sat_inc(cnt_q);
    full_c      = !word_open(cnt_inc_c);
    word_sh_c   = word_open(cnt_q) ? {word_q[WORD_BITS-2:0], bit_d} : word_q;
    err_set_c   = 1'b0;
    state_d     = state_q;
    lr_prev_d   = lr_prev_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    pcm_left_d  = pcm_left_q;
    pcm_right_d = pcm_right_q;
    pcm_valid_d = 1'b0;
    bit_cnt_d   = bit_cnt_q;

    // lrclk history keeps tracking while disabled so re-enable cannot see a stale edge
    if (bit_vld) lr_prev_d = bit_lrclk;

    if (!enable) begin
      state_d   = ST_ALIGN;
      cnt_d     = '0;
      left_ok_d = 1'b0;
    end else if (bit_vld) begin
      case (state_q)
        ST_LEFT, ST_RIGHT: begin
          word_d = word_sh_c;
          cnt_d  = cnt_inc_c;
          if (trans_c) begin
            bit_cnt_d = cnt_inc_c;
            cnt_d     = '0;
            err_set_c = !full_c;
            if (state_q == ST_LEFT) begin
              left_hold_d = word_sh_c;
              left_ok_d   = full_c;
              state_d     = ST_RIGHT;
            end else begin
              state_d = ST_LEFT;
              if (left_ok_q && full_c) begin
                pcm_left_d  = left_hold_q;
                pcm_right_d = word_sh_c;
                pcm_valid_d = 1'b1;
              end
            end
          end
        end
        default: begin
          if (trans_c && !bit_lrclk) begin
            state_d = ST_LEFT;
            cnt_d   = '0;
          end
        end
      endcase
    end

    frame_err_d = err_clr ? 1'b0 : (frame_err_q | err_set_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ALIGN;
      lr_prev_q   <= 1'b0;
      cnt_q       <= '0;
      word_q      <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      pcm_left_q  <= '0;
      pcm_right_q <= '0;
      pcm_valid_q <= 1'b0;
      bit_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lr_prev_q   <= lr_prev_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      pcm_left_q  <= pcm_left_d;
      pcm_right_q <= pcm_right_d;
      pcm_valid_q <= pcm_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign pcm_left  = pcm_left_q;
  assign pcm_right = pcm_right_q;
  assign pcm_valid = pcm_valid_q;
  assign bit_cnt   = bit_cnt_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_frame_receiver.sv
// Randomized self-checking bench for i2s_frame_receiver; expected pairs come
// from a word-level model of the I2S stream (clk = 8x bclk).
module tb_i2s_frame_receiver;

  logic        clk = 1'b0;
  logic        reset, enable, i2s_bclk, i2s_lrclk, i2s_d, err_clr;
  logic [23:0] pcm_left, pcm_right;
  logic        pcm_valid;
  logic [7:0]  bit_cnt;
  logic        frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rise = 0;

  typedef struct { logic [23:0] l; logic [23:0] r; int cnt; int lat; } pair_t;
  typedef struct { bit lr; int n; logic [23:0] data; } word_t;

  pair_t obs_q[$];
  word_t stim_q[$];

  i2s_frame_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_d     (i2s_d),
    .pcm_left  (pcm_left),
    .pcm_right (pcm_right),
    .pcm_valid (pcm_valid),
    .bit_cnt   (bit_cnt),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every pcm_valid cycle with its latency from the last bclk rise
  always @(posedge clk) begin
    #1;
    if (pcm_valid === 1'b1)
      obs_q.push_back('{l: pcm_left, r: pcm_right, cnt: int'(bit_cnt), lat: cyc - last_rise});
  end

  task automatic send_bit(input bit lr, input bit dv, input bit clr);
    i2s_lrclk = lr;
    i2s_d     = dv;
    i2s_bclk  = 1'b0;
    repeat (4) @(negedge clk);
    i2s_bclk  = 1'b1;
    last_rise = cyc;
    repeat (3) @(negedge clk);
    err_clr = clr;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic add_word(input bit lr, input int n, input logic [23:0] data);
    stim_q.push_back('{lr: lr, n: n, data: data});
  endtask

  // I2S: a word's last slot is sent with the following word's lrclk level
  task automatic send_words(input bit final_lr, input int clr_idx);
    for (int i = 0; i < stim_q.size(); i++) begin
      bit nlr;
      nlr = (i + 1 < stim_q.size()) ? stim_q[i+1].lr : final_lr;
      for (int k = 0; k < stim_q[i].n; k++) begin
        bit b;
        b = (k < 24) ? stim_q[i].data[23-k] : 1'($urandom);
        send_bit((k == stim_q[i].n - 1) ? nlr : stim_q[i].lr, b,
                 (i == clr_idx) && (k == stim_q[i].n - 1));
      end
    end
  endtask

  task automatic idle(input int n);
    i2s_bclk = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    idle(4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    stim_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pcm_left !== 24'h0) begin bad++; $display("FAIL rst_left: got %h want 000000", pcm_left); end
    total++; if (pcm_right !== 24'h0) begin bad++; $display("FAIL rst_right: got %h want 000000", pcm_right); end
    total++; if (pcm_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", pcm_valid); end
    total++; if (bit_cnt !== 8'd0) begin bad++; $display("FAIL rst_bitcnt: got %0d want 0", bit_cnt); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_frame32();
    do_reset();
    add_word(1, 32, 24'($urandom));
    add_word(0, 32, 24'hA5A5A5);
    add_word(1, 32, 24'h5A5A5A);
    send_words(1'b0, -1);
    idle(8);
    total++;
    if (obs_q.size() != 1) begin bad++; $display("FAIL f32_pulses: got %0d want 1", obs_q.size()); end
    else begin
      total++; if (obs_q[0].l !== 24'hA5A5A5) begin bad++; $display("FAIL f32_left: got %h want a5a5a5", obs_q[0].l); end
      total++; if (obs_q[0].r !== 24'h5A5A5A) begin bad++; $display("FAIL f32_right: got %h want 5a5a5a", obs_q[0].r); end
      total++; if (obs_q[0].cnt != 32) begin bad++; $display("FAIL f32_bitcnt: got %0d want 32", obs_q[0].cnt); end
      total++; if (obs_q[0].lat != 4) begin bad++; $display("FAIL f32_latency: got %0d want 4", obs_q[0].lat); end
    end
    total++; if (pcm_valid !== 1'b0) begin bad++; $display("FAIL f32_valid_low: got %b want 0", pcm_valid); end
  endtask

  task automatic test_frame24();
    do_reset();
    add_word(1, 24, 24'($urandom));
    add_word(0, 24, 24'h800001);
    add_word(1, 24, 24'h7FFFFF);
    send_words(1'b0, -1);
    idle(8);
    total++;
    if (obs_q.size() != 1) begin bad++; $display("FAIL f24_pulses: got %0d want 1", obs_q.size()); end
    else begin
      total++; if (obs_q[0].l !== 24'h800001) begin bad++; $display("FAIL f24_left: got %h want 800001", obs_q[0].l); end
      total++; if (obs_q[0].r !== 24'h7FFFFF) begin bad++; $display("FAIL f24_right: got %h want 7fffff", obs_q[0].r); end
    end
    total++; if (bit_cnt !== 8'd24) begin bad++; $display("FAIL f24_bitcnt: got %0d want 24", bit_cnt); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL f24_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_short_word();
    logic [23:0] b, c;
    b = 24'($urandom);
    c = 24'($urandom);
    do_reset();
    add_word(1, 32, 24'($urandom));
    add_word(0, 32, 24'($urandom));
    add_word(1, 16, 24'($urandom));
    add_word(0, 32, b);
    add_word(1, 32, c);
    send_words(1'b0, -1);
    idle(8);
    total++;
    if (obs_q.size() != 1) begin bad++; $display("FAIL short_pulses: got %0d want 1", obs_q.size()); end
    else begin
      total++; if (obs_q[0].l !== b) begin bad++; $display("FAIL short_next_left: got %h want %h", obs_q[0].l, b); end
      total++; if (obs_q[0].r !== c) begin bad++; $display("FAIL short_next_right: got %h want %h", obs_q[0].r, c); end
    end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_ferr: got %b want 1", frame_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL short_clr: got %b want 0", frame_err); end
  endtask

  task automatic test_err_clr_priority();
    do_reset();
    add_word(1, 32, 24'($urandom));
    add_word(0, 32, 24'($urandom));
    add_word(1, 16, 24'($urandom));
    send_words(1'b0, 2);
    idle(8);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL clrprio_ferr: got %b want 0", frame_err); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL clrprio_pulses: got %0d want 0", obs_q.size()); end
    total++; if (bit_cnt !== 8'd16) begin bad++; $display("FAIL clrprio_bitcnt: got %0d want 16", bit_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] c, d;
    c = 24'($urandom);
    d = 24'($urandom);
    do_reset();
    add_word(1, 32, 24'($urandom));
    add_word(0, 32, 24'($urandom) | 24'h1);
    add_word(1, 32, 24'($urandom));
    send_words(1'b0, -1);
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL rmid_first_pair: got %0d want 1", obs_q.size()); end
    for (int k = 0; k < 10; k++) send_bit(1'b0, 1'($urandom), 1'b0);
    do_reset();
    total++; if (pcm_left !== 24'h0) begin bad++; $display("FAIL rmid_left: got %h want 000000", pcm_left); end
    total++; if (pcm_right !== 24'h0) begin bad++; $display("FAIL rmid_right: got %h want 000000", pcm_right); end
    total++; if (bit_cnt !== 8'd0) begin bad++; $display("FAIL rmid_bitcnt: got %0d want 0", bit_cnt); end
    add_word(0, 22, 24'($urandom));
    add_word(1, 32, 24'($urandom));
    add_word(0, 32, c);
    add_word(1, 32, d);
    send_words(1'b0, -1);
    idle(8);
    total++;
    if (obs_q.size() != 1) begin bad++; $display("FAIL rmid_pulses: got %0d want 1", obs_q.size()); end
    else begin
      total++; if (obs_q[0].l !== c) begin bad++; $display("FAIL rmid_pair_left: got %h want %h", obs_q[0].l, c); end
      total++; if (obs_q[0].r !== d) begin bad++; $display("FAIL rmid_pair_right: got %h want %h", obs_q[0].r, d); end
    end
  endtask

  task automatic test_enable_drop();
    logic [23:0] a, b, d, e;
    a = 24'($urandom);
    b = 24'($urandom);
    d = 24'($urandom);
    e = 24'($urandom);
    do_reset();
    add_word(1, 32, 24'($urandom));
    add_word(0, 32, a);
    add_word(1, 32, b);
    add_word(0, 32, 24'($urandom));
    send_words(1'b1, -1);
    for (int k = 0; k < 10; k++) send_bit(1'b1, 1'($urandom), 1'b0);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'($urandom), 1'b0);
    total++; if (pcm_left !== a) begin bad++; $display("FAIL en_hold_left: got %h want %h", pcm_left, a); end
    total++; if (pcm_right !== b) begin bad++; $display("FAIL en_hold_right: got %h want %h", pcm_right, b); end
    total++; if (bit_cnt !== 8'd32) begin bad++; $display("FAIL en_hold_bitcnt: got %0d want 32", bit_cnt); end
    enable = 1'b1;
    stim_q.delete();
    add_word(1, 17, 24'($urandom));
    add_word(0, 32, d);
    add_word(1, 32, e);
    send_words(1'b0, -1);
    idle(8);
    total++;
    if (obs_q.size() != 2) begin bad++; $display("FAIL en_pulses: got %0d want 2", obs_q.size()); end
    else begin
      total++; if (obs_q[1].l !== d) begin bad++; $display("FAIL en_realign_left: got %h want %h", obs_q[1].l, d); end
      total++; if (obs_q[1].r !== e) begin bad++; $display("FAIL en_realign_right: got %h want %h", obs_q[1].r, e); end
    end
  endtask

  task automatic test_long_words();
    logic [23:0] a, b, c, d;
    a = 24'($urandom);
    b = 24'($urandom);
    c = 24'($urandom);
    d = 24'($urandom);
    do_reset();
    add_word(1, 64, 24'($urandom));
    add_word(0, 64, a);
    add_word(1, 64, b);
    add_word(0, 32, c);
    add_word(1, 300, d);
    send_words(1'b0, -1);
    idle(8);
    total++;
    if (obs_q.size() != 2) begin bad++; $display("FAIL long_pulses: got %0d want 2", obs_q.size()); end
    else begin
      total++; if (obs_q[0].l !== a) begin bad++; $display("FAIL long64_left: got %h want %h", obs_q[0].l, a); end
      total++; if (obs_q[0].r !== b) begin bad++; $display("FAIL long64_right: got %h want %h", obs_q[0].r, b); end
      total++; if (obs_q[0].cnt != 64) begin bad++; $display("FAIL long64_bitcnt: got %0d want 64", obs_q[0].cnt); end
      total++; if (obs_q[0].lat != 4) begin bad++; $display("FAIL long64_latency: got %0d want 4", obs_q[0].lat); end
      total++; if (obs_q[1].r !== d) begin bad++; $display("FAIL sat_right: got %h want %h", obs_q[1].r, d); end
      total++; if (obs_q[1].cnt != 255) begin bad++; $display("FAIL sat_bitcnt: got %0d want 255", obs_q[1].cnt); end
    end
  endtask

  task automatic test_random();
    int lens[6] = '{16, 23, 24, 25, 32, 48};
    for (int it = 0; it < 3; it++) begin
      pair_t exp_q[$];
      bit    err_exp;
      int    last_n;
      do_reset();
      add_word(1, lens[$urandom_range(5, 0)], 24'($urandom));
      for (int w = 0; w < 6; w++) add_word(w % 2 == 1, lens[$urandom_range(5, 0)], 24'($urandom));
      // Word-level reference: after the lead word, words pair up as (left, right)
      err_exp = 1'b0;
      for (int p = 1; p + 1 < stim_q.size(); p += 2) begin
        if (stim_q[p].n < 24 || stim_q[p+1].n < 24) err_exp = 1'b1;
        else exp_q.push_back('{l: stim_q[p].data, r: stim_q[p+1].data,
                               cnt: (stim_q[p+1].n > 255) ? 255 : stim_q[p+1].n, lat: 4});
      end
      last_n = stim_q[stim_q.size()-1].n;
      send_words(1'b0, -1);
      idle(8);
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rnd_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          total++;
          if (obs_q[i].l !== exp_q[i].l || obs_q[i].r !== exp_q[i].r || obs_q[i].cnt != exp_q[i].cnt ||
              obs_q[i].lat != exp_q[i].lat) begin
            bad++;
            $display("FAIL rnd_pair%0d: got %h/%h cnt %0d lat %0d want %h/%h cnt %0d lat %0d", i,
                     obs_q[i].l, obs_q[i].r, obs_q[i].cnt, obs_q[i].lat,
                     exp_q[i].l, exp_q[i].r, exp_q[i].cnt, exp_q[i].lat);
          end
        end
      end
      total++; if (frame_err !== err_exp) begin bad++; $display("FAIL rnd_ferr: got %b want %b", frame_err, err_exp); end
      total++; if (int'(bit_cnt) != last_n) begin bad++; $display("FAIL rnd_bitcnt: got %0d want %0d", bit_cnt, last_n); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    i2s_bclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_d     = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_frame32();
    test_frame24();
    test_short_word();
    test_err_clr_priority();
    test_reset_mid_frame();
    test_enable_drop();
    test_long_words();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_frame_receiver.md
I2S_FRAME_RECEIVER -- requirements
Module: i2s_frame_receiver

Interface
REQ-001 SHALL have parameter WORD_BITS, default 24, meaning PCM sample width captured per channel, MSB first.
REQ-002 SHALL have parameter CNT_BITS, default 8, meaning width of the bit-count status output.
REQ-003 SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1, receiver run; low forces ALIGN.
REQ-006 SHALL have ports i2s_bclk, i2s_lrclk and i2s_d, input, 1 each, asynchronous PCM9211 I2S bit clock, word clock (0 = left) and data.
REQ-007 SHALL have ports pcm_left and pcm_right, output, WORD_BITS each, last complete stereo pair.
REQ-008 SHALL have port pcm_valid, output, 1, one-clk pulse when pcm_left/pcm_right update.
REQ-009 SHALL have port bit_cnt, output, CNT_BITS, bit count of the last closed word.
REQ-010 SHALL have port frame_err, output, 1, sticky short-word flag.
REQ-011 SHALL have port err_clr, input, 1, clears frame_err.

Function
REQ-012 SHALL pass i2s_bclk, i2s_lrclk and i2s_d each through a 2-flop synchronizer of equal depth; a bclk rise SHALL be detected as sync=1 & previous sync=0; clk SHALL be >= 8x bclk.
REQ-013 SHALL process only on a detected bclk rise ("bit event"), using the synchronized lrclk and d values of that cycle.
REQ-014 SHALL flag a bit event as a transition when lrclk differs from lrclk at the previous bit event.
REQ-015 SHALL run an FSM with states ALIGN, LEFT and RIGHT: ALIGN->LEFT on a 1->0 transition; LEFT->RIGHT on a 0->1 transition; RIGHT->LEFT on a 1->0 transition; any state->ALIGN when enable=0.
REQ-016 SHALL close the current word at a transition bit event; that event's data bit is the previous word's LSB slot, I2S one-bclk delay; the next bit event is the MSB of the new word.
REQ-017 SHALL shift d into the word register MSB-first while the word counter < WORD_BITS and ignore further bits.
REQ-018 SHALL saturate the word counter at 2^CNT_BITS-1 and include the closing transition bit in the count.
REQ-019 SHALL load bit_cnt with the counter value whenever a word closes, and SHALL then reset the counter to 0 for the new word.
REQ-020 SHALL treat a word closing with count < WORD_BITS as short: set frame_err, discard the pair, and not pulse pcm_valid for it.
REQ-021 SHALL, on a RIGHT->LEFT close with both words full, load pcm_left and pcm_right together and assert pcm_valid exactly 1 clk, the cycle after the bit event.
REQ-022 SHALL keep pcm_valid latency, from the clk edge that first samples i2s_bclk high, at 4 clk cycles.
REQ-023 SHALL produce no output for the word in progress at the ALIGN->LEFT transition.
REQ-024 SHALL give err_clr priority over a simultaneous set, so that frame_err=0 that cycle; the set is lost.
REQ-025 SHALL, when enable drops, abandon partial words, zero the counter, hold pcm_left/pcm_right/bit_cnt, and keep pcm_valid=0.
REQ-026 SHALL provide no backpressure; an unconsumed pair is overwritten.

Reset
REQ-027 SHALL, on reset=1 at a clk edge, clear to 0 pcm_left, pcm_right, pcm_valid, bit_cnt, frame_err, word registers, counter, synchronizers and previous-lrclk; state SHALL become ALIGN.
REQ-028 SHALL abandon a frame in progress on reset mid-frame; after release, the first valid pair SHALL be the first full pair following the next 1->0 lrclk transition.

Structure
REQ-029 SHALL place the FSM state encoding (ALIGN/LEFT/RIGHT) and the WORD_BITS/CNT_BITS defaults in the shared audio package.
REQ-030 SHALL implement the 2-flop synchronizer plus rise detect as sub-module i2s_input_sync, instanced once for the three inputs.

Verification
REQ-031 SHALL verify: enable=1, 32-bit frames, left=0xA5A5A5, right=0x5A5A5A -> after the second 1->0 lrclk, pcm_left=0xA5A5A5, pcm_right=0x5A5A5A, one pcm_valid pulse, bit_cnt=32.
REQ-032 SHALL verify: 24-bit frames, left=0x800001, right=0x7FFFFF -> exact values, bit_cnt=24, frame_err=0.
REQ-033 SHALL verify: one right word of 16 bits -> frame_err=1, no pcm_valid that frame, next good pair valid; err_clr with a simultaneous short word -> frame_err=0.
REQ-034 SHALL verify: reset pulse mid-left-word -> all outputs 0, no pcm_valid until the pair after the next 1->0 lrclk.
REQ-035 SHALL verify: enable dropped mid-right-word, then restored -> outputs hold, pcm_valid=0, realign on the next 1->0 lrclk.
REQ-036 SHALL verify: 64-bit words at clk=8x bclk -> bit_cnt=64, data = first 24 bits, pcm_valid latency = 4 clk.
